vga_display_ctrl: RTL and testbench
===================================

Name: vga_display_ctrl

Overview:
- Parametrised successor to the fixed-format VGA core. Generates programmable H/V timing, issues fixed-latency pixel fetches to the frame buffer, and drives registered sync and RGB outputs.
- Adds generic colour depth, selectable sync polarity, three built-in test patterns, a frame-start strobe and sticky underflow detection.
- Sits between the frame buffer and the board pins, in the 25 MHz pixel-clock domain.

Parameters:
- CW, 1, bits per colour channel (RGB bus is 3*CW).
- H_ACT, 640, active pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACT, 480, active lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).
- H_POL, 0, active level of h_sync (0 = active-low).
- V_POL, 0, active level of v_sync (0 = active-low).
- FETCH_LAT, 2, frame-buffer read latency in cycles; legal range 1..4.

Ports:
- clk  in  1  pixel clock.
- reset_  in  1  asynchronous active-low reset.
- i_enable  in  1  run timing; low forces idle.
- i_mode  in  2  0 = frame buffer, 1 = colour bars, 2 = checkerboard, 3 = solid white.
- i_pixel_rgb  in  3*CW  returned pixel, ordered {r,g,b}.
- i_pixel_valid  in  1  i_pixel_rgb is valid this cycle.
- o_fetch_next_pixel  out  1  read request to the frame buffer.
- o_frame_start  out  1  one-cycle pulse at pixel (0,0).
- o_h_sync  out  1  horizontal sync.
- o_v_sync  out  1  vertical sync.
- o_rgb  out  3*CW  pixel output, ordered {r,g,b}.
- o_underflow  out  1  sticky: pixel data missing this frame.

Behaviour:
- Reset and idle outputs:
  - Clock is clk; reset_ is asynchronous active-low.
  - On reset: counters = 0, mode register = 0, o_rgb = 0, o_fetch_next_pixel = 0, o_frame_start = 0, o_underflow = 0.
  - o_h_sync = ~H_POL and o_v_sync = ~V_POL (inactive).
  - While i_enable is low, the block holds the reset state synchronously.
- Counters:
  - h_cnt runs 0..H_TOT-1, where H_TOT = H_ACT+H_FP+H_SYNC+H_BP.
  - v_cnt increments when h_cnt wraps and runs 0..V_TOT-1.
  - Both wrap to 0. The first enabled cycle has counter (0,0).
- Active and sync regions:
  - Active when h_cnt < H_ACT and v_cnt < V_ACT.
  - h sync region: H_ACT+H_FP <= h_cnt < H_ACT+H_FP+H_SYNC. v sync region is analogous on v_cnt.
- Output latency: all outputs are registered. o_h_sync, o_v_sync, o_rgb and o_frame_start at cycle k+1 reflect the counter value at cycle k.
- Fetch:
  - o_fetch_next_pixel is high in exactly those cycles where the position FETCH_LAT cycles later in raster order is active.
  - The lookahead wraps across line and frame ends.
  - Exactly H_ACT*V_ACT fetches are issued per frame. The frame buffer resets its read pointer on its own.
- Data capture:
  - In mode 0, i_pixel_rgb is sampled in the cycle the counter is at the active position, i.e. FETCH_LAT cycles after the matching fetch.
  - If i_pixel_valid is low in that cycle: o_rgb = 0 for that pixel and o_underflow is set.
  - o_underflow clears only on o_frame_start or reset. Underflow in the same cycle as frame start: set wins.
  - i_pixel_valid outside active sample cycles is ignored.
- Blanking: o_rgb = 0 whenever not active, in every mode.
- Test patterns (ignore i_pixel_rgb and never flag underflow; fetches still issue):
  - Mode 1: 8 vertical bars, bar index b = h_cnt*8/H_ACT. Colour {r,g,b} = {b[2],b[1],b[0]}, each bit replicated CW times.
  - Mode 2: checkerboard of 8x8 pixels, white when h_cnt[3]^v_cnt[3], else black.
  - Mode 3: all channels all-ones.
- Mode changes: i_mode is sampled only in the cycle the counter is at (0,0). A change mid-frame takes effect at the next frame.
- Reset mid-frame: asynchronous return to the reset state. No partial fetch pulse may remain high after reset_ falls.
- Enable: falling i_enable acts as a synchronous reset on the next edge. Rising i_enable starts at (0,0) with o_frame_start pulsing one cycle later.

Decomposition:
- Shared package vga_pkg:
  - Default 640x480@60 timing constants.
  - Mode encodings MODE_FB, MODE_BARS, MODE_CHECK, MODE_WHITE.
  - Derived H_TOT/V_TOT function.
- Sub-module vga_timing_counter: h/v counters plus active/sync decode for a given offset.
  - Instanced twice: display position, and fetch lookahead offset by FETCH_LAT.
- Pattern generator and data path stay in the top level.

Test Plan:
- Reset/idle: assert reset_ low mid-line and run with i_enable=0 -> o_rgb=0, syncs inactive (high with POL=0), o_fetch_next_pixel=0, o_underflow=0.
- Small timing: H_ACT=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACT=4, V_FP=1, V_SYNC=2, V_BP=1 -> h_sync low for 3 cycles of every 14, v_sync low for 28 cycles, o_frame_start once every 112 cycles.
- Fetch alignment: FETCH_LAT=2, model returns h_cnt value two cycles after each fetch -> o_rgb shows 0..7 per active line, 32 fetches per frame, o_underflow stays 0.
- Underflow: drop i_pixel_valid for one pixel at (3,1) -> o_rgb=0 for that pixel, o_underflow=1 until the next o_frame_start, then 0.
- Patterns: CW=2, mode 1 -> bar 5 drives o_rgb=6'b110011. Mode 3 -> 6'b111111 in active, 0 in blanking.
- Mode switch: change i_mode 0->2 at mid-frame (v_cnt=2) -> current frame stays frame-buffer data; the next frame shows the checkerboard from pixel (0,0).

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing defaults, display modes and counter sizing helpers
package vga_pkg;

    localparam int DEF_H_ACT  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_ACT  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    typedef enum logic [1:0] {
        MODE_FB    = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_WHITE = 2'd3
    } vga_mode_e;

    function automatic int calc_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    // Never narrower than 4 bits so the checkerboard can always read bit 3.
    function automatic int cnt_width(input int total);
        int w;
        w = $clog2(total);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// rtl/vga_timing_counter.sv - raster h/v counters with active and sync-region decode
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int H_ACT  = DEF_H_ACT,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_ACT  = DEF_V_ACT,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter int OFFSET = 0,
    parameter int HW     = cnt_width(calc_total(H_ACT, H_FP, H_SYNC, H_BP)),
    parameter int VW     = cnt_width(calc_total(V_ACT, V_FP, V_SYNC, V_BP))
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          i_enable,
    output logic [HW-1:0] o_h_cnt,
    output logic [VW-1:0] o_v_cnt,
    output logic          o_active,
    output logic          o_h_sync_region,
    output logic          o_v_sync_region
);

    localparam int H_TOT = calc_total(H_ACT, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = calc_total(V_ACT, V_FP, V_SYNC, V_BP);

    // Idle/reset position is OFFSET pixels ahead of (0,0) in raster order.
    localparam logic [HW-1:0] H_START = HW'(OFFSET % H_TOT);
    localparam logic [VW-1:0] V_START = VW'((OFFSET / H_TOT) % V_TOT);
    localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_h_cnt <= H_START;
            r_v_cnt <= V_START;
        end else if (!i_enable) begin
            r_h_cnt <= H_START;
            r_v_cnt <= V_START;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
        end
    end

    assign o_h_cnt         = r_h_cnt;
    assign o_v_cnt         = r_v_cnt;
    assign o_active        = (r_h_cnt < HW'(H_ACT)) && (r_v_cnt < VW'(V_ACT));
    assign o_h_sync_region = (r_h_cnt >= HW'(H_ACT + H_FP)) && (r_h_cnt < HW'(H_ACT + H_FP + H_SYNC));
    assign o_v_sync_region = (r_v_cnt >= VW'(V_ACT + V_FP)) && (r_v_cnt < VW'(V_ACT + V_FP + V_SYNC));

endmodule

// File: rtl/vga_display_ctrl.sv
// rtl/vga_display_ctrl.sv - programmable VGA timing, frame-buffer fetch, test patterns and sync/RGB output
module vga_display_ctrl
    import vga_pkg::*;
#(
    parameter int CW        = 1,
    parameter int H_ACT     = DEF_H_ACT,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACT     = DEF_V_ACT,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int H_POL     = 0,
    parameter int V_POL     = 0,
    parameter int FETCH_LAT = 2
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            i_enable,
    input  logic [1:0]      i_mode,
    input  logic [3*CW-1:0] i_pixel_rgb,
    input  logic            i_pixel_valid,
    output logic            o_fetch_next_pixel,
    output logic            o_frame_start,
    output logic            o_h_sync,
    output logic            o_v_sync,
    output logic [3*CW-1:0] o_rgb,
    output logic            o_underflow
);

    localparam int   HW    = cnt_width(calc_total(H_ACT, H_FP, H_SYNC, H_BP));
    localparam int   VW    = cnt_width(calc_total(V_ACT, V_FP, V_SYNC, V_BP));
    localparam logic HS_ON = (H_POL != 0);
    localparam logic VS_ON = (V_POL != 0);

    logic [HW-1:0]   w_h_cnt;
    logic [VW-1:0]   w_v_cnt;
    logic            w_active;
    logic            w_h_sync_region;
    logic            w_v_sync_region;
    logic [HW-1:0]   w_unused_la_h_cnt;
    logic [VW-1:0]   w_unused_la_v_cnt;
    logic            w_unused_la_h_sync;
    logic            w_unused_la_v_sync;
    logic            w_la_active;

    logic            w_frame0;
    vga_mode_e       w_mode_eff;
    logic [2:0]      w_bar;
    logic [3*CW-1:0] w_pix;
    logic            w_uf_set;

    logic            w_nxt_fetch, w_nxt_frame_start, w_nxt_h_sync, w_nxt_v_sync, w_nxt_underflow;
    logic [3*CW-1:0] w_nxt_rgb;
    vga_mode_e       w_nxt_mode;

    logic            r_fetch, r_frame_start, r_h_sync, r_v_sync, r_underflow;
    logic [3*CW-1:0] r_rgb;
    vga_mode_e       r_mode;

    vga_timing_counter #(
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .OFFSET(0), .HW(HW), .VW(VW)
    ) u_disp (
        .clk(clk), .reset_(reset_), .i_enable(i_enable),
        .o_h_cnt(w_h_cnt), .o_v_cnt(w_v_cnt), .o_active(w_active),
        .o_h_sync_region(w_h_sync_region), .o_v_sync_region(w_v_sync_region)
    );

    // One extra step of lookahead absorbs the fetch output register, so the
    // request leaves the pins exactly FETCH_LAT cycles before its pixel.
    vga_timing_counter #(
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .OFFSET(FETCH_LAT + 1), .HW(HW), .VW(VW)
    ) u_fetch (
        .clk(clk), .reset_(reset_), .i_enable(i_enable),
        .o_h_cnt(w_unused_la_h_cnt), .o_v_cnt(w_unused_la_v_cnt), .o_active(w_la_active),
        .o_h_sync_region(w_unused_la_h_sync), .o_v_sync_region(w_unused_la_v_sync)
    );

    assign w_frame0   = (w_h_cnt == '0) && (w_v_cnt == '0);
    assign w_mode_eff = w_frame0 ? vga_mode_e'(i_mode) : r_mode;
    assign w_bar      = 3'((int'(w_h_cnt) * 8) / H_ACT);

    always_comb begin
        w_pix    = '0;
        w_uf_set = 1'b0;
        if (w_active) begin
            case (w_mode_eff)
                MODE_FB: begin
                    if (i_pixel_valid) w_pix = i_pixel_rgb;
                    else               w_uf_set = 1'b1;
                end
                MODE_BARS:  w_pix = {{CW{w_bar[2]}}, {CW{w_bar[1]}}, {CW{w_bar[0]}}};
                MODE_CHECK: w_pix = (w_h_cnt[3] ^ w_v_cnt[3]) ? '1 : '0;
                MODE_WHITE: w_pix = '1;
            endcase
        end
    end

    always_comb begin
        w_nxt_fetch       = 1'b0;
        w_nxt_frame_start = 1'b0;
        w_nxt_h_sync      = ~HS_ON;
        w_nxt_v_sync      = ~VS_ON;
        w_nxt_rgb         = '0;
        w_nxt_underflow   = 1'b0;
        w_nxt_mode        = MODE_FB;
        if (i_enable) begin
            w_nxt_fetch       = w_la_active;
            w_nxt_frame_start = w_frame0;
            w_nxt_h_sync      = w_h_sync_region ? HS_ON : ~HS_ON;
            w_nxt_v_sync      = w_v_sync_region ? VS_ON : ~VS_ON;
            w_nxt_rgb         = w_pix;
            w_nxt_mode        = w_mode_eff;
            // A miss on pixel (0,0) survives the frame-start clear.
            w_nxt_underflow   = w_uf_set | (r_underflow & ~w_frame0);
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_fetch       <= 1'b0;
            r_frame_start <= 1'b0;
            r_h_sync      <= ~HS_ON;
            r_v_sync      <= ~VS_ON;
            r_rgb         <= '0;
            r_underflow   <= 1'b0;
            r_mode        <= MODE_FB;
        end else begin
            r_fetch       <= w_nxt_fetch;
            r_frame_start <= w_nxt_frame_start;
            r_h_sync      <= w_nxt_h_sync;
            r_v_sync      <= w_nxt_v_sync;
            r_rgb         <= w_nxt_rgb;
            r_underflow   <= w_nxt_underflow;
            r_mode        <= w_nxt_mode;
        end
    end

    assign o_fetch_next_pixel = r_fetch;
    assign o_frame_start      = r_frame_start;
    assign o_h_sync           = r_h_sync;
    assign o_v_sync           = r_v_sync;
    assign o_rgb              = r_rgb;
    assign o_underflow        = r_underflow;

endmodule

// File: tb/tb_vga_display_ctrl.sv
// tb/tb_vga_display_ctrl.sv - raster-model bench for vga_display_ctrl on a 14x8 small-timing frame
module tb_vga_display_ctrl;

    localparam int CW = 2;
    localparam int H_ACT = 8, H_FP = 2, H_SYNC = 3, H_BP = 1;
    localparam int V_ACT = 4, V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int LAT = 2;
    localparam int H_TOT = 14, V_TOT = 8, F_TOT = 112;

    logic       clk = 1'b0;
    logic       reset_;
    logic       i_enable;
    logic [1:0] i_mode;
    logic [5:0] i_pixel_rgb;
    logic       i_pixel_valid;
    logic       o_fetch_next_pixel, o_frame_start, o_h_sync, o_v_sync, o_underflow;
    logic [5:0] o_rgb;

    always #5 clk = ~clk;

    vga_display_ctrl #(
        .CW(CW), .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .H_POL(0), .V_POL(0), .FETCH_LAT(LAT)
    ) dut (
        .clk(clk), .reset_(reset_), .i_enable(i_enable), .i_mode(i_mode),
        .i_pixel_rgb(i_pixel_rgb), .i_pixel_valid(i_pixel_valid),
        .o_fetch_next_pixel(o_fetch_next_pixel), .o_frame_start(o_frame_start),
        .o_h_sync(o_h_sync), .o_v_sync(o_v_sync), .o_rgb(o_rgb), .o_underflow(o_underflow)
    );

    int n_vec = 0;
    int n_err = 0;

    int         pos;
    logic [1:0] m_mode;
    logic       e_hs, e_vs, e_fs, e_fetch, e_uf;
    logic [5:0] e_rgb;
    bit         fh[$];
    int         drop_pos = -1;
    int         c_hs, c_vs, c_fs, c_fe;

    function automatic bit is_act(input int p);
        return ((p % H_TOT) < H_ACT) && ((p / H_TOT) < V_ACT);
    endfunction

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t, pos=%0d)", name, act, exp, $time, pos);
        end
    endtask

    task automatic model_reset();
        pos = 0; m_mode = 2'd0;
        e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_fetch = 1'b0; e_uf = 1'b0; e_rgb = 6'd0;
        fh = {};
        repeat (LAT) fh.push_back(1'b0);
    endtask

    task automatic check_all();
        chk("h_sync",      6'(o_h_sync),           6'(e_hs));
        chk("v_sync",      6'(o_v_sync),           6'(e_vs));
        chk("frame_start", 6'(o_frame_start),      6'(e_fs));
        chk("fetch",       6'(o_fetch_next_pixel), 6'(e_fetch));
        chk("underflow",   6'(o_underflow),        6'(e_uf));
        chk("rgb",         o_rgb,                  e_rgb);
    endtask

    // Frame buffer: answers each fetch LAT cycles later with the h coordinate of the pixel.
    task automatic drive_fb();
        bit v;
        v = fh.pop_front();
        fh.push_back(o_fetch_next_pixel);
        if (pos == drop_pos) v = 1'b0;
        i_pixel_valid = v;
        i_pixel_rgb   = v ? 6'(pos % H_TOT) : 6'($urandom);
    endtask

    task automatic model_edge();
        int h, v;
        logic [1:0] me;
        logic [2:0] bb;
        bit a;
        if (!reset_ || !i_enable) begin
            model_reset();
            return;
        end
        h = pos % H_TOT;
        v = pos / H_TOT;
        a = is_act(pos);
        e_hs = !(h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SYNC);
        e_vs = !(v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SYNC);
        e_fs = (pos == 0);
        me = (pos == 0) ? i_mode : m_mode;
        if (pos == 0) m_mode = i_mode;
        bb = 3'(h * 8 / H_ACT);
        e_rgb = 6'd0;
        if (a) begin
            case (me)
                2'd0: e_rgb = i_pixel_valid ? i_pixel_rgb : 6'd0;
                2'd1: e_rgb = {bb[2], bb[2], bb[1], bb[1], bb[0], bb[0]};
                2'd2: e_rgb = ((((h / 8) ^ (v / 8)) % 2) == 1) ? 6'h3f : 6'h00;
                default: e_rgb = 6'h3f;
            endcase
        end
        e_uf = (a && me == 2'd0 && !i_pixel_valid) || (e_uf && pos != 0);
        e_fetch = is_act((pos + 1 + LAT) % F_TOT);
        pos = (pos + 1) % F_TOT;
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        drive_fb();
        model_edge();
        @(posedge clk);
        #1;
        if (!o_h_sync) c_hs++;
        if (!o_v_sync) c_vs++;
        if (o_frame_start) c_fs++;
        if (o_fetch_next_pixel) c_fe++;
    endtask

    // Advance until the outputs show pixel (h,v).
    task automatic goto_px(input int h, input int v);
        int tgt;
        tgt = (v * H_TOT + h + 1) % F_TOT;
        for (int i = 0; i <= F_TOT && pos != tgt; i++) tick();
    endtask

    initial begin
        reset_ = 1'b0; i_enable = 1'b0; i_mode = 2'd0;
        i_pixel_rgb = 6'd0; i_pixel_valid = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("rst_h_sync", 6'(o_h_sync), 6'd1);
        chk("rst_v_sync", 6'(o_v_sync), 6'd1);
        chk("rst_fetch",  6'(o_fetch_next_pixel), 6'd0);
        chk("rst_rgb",    o_rgb, 6'd0);

        reset_ = 1'b1;
        repeat (3) tick();
        i_enable = 1'b1;
        repeat (F_TOT) tick();

        c_hs = 0; c_vs = 0; c_fs = 0; c_fe = 0;
        repeat (F_TOT) tick();
        chk("hs_low_per_frame", 6'(c_hs), 6'd24);
        chk("vs_low_per_frame", 6'(c_vs), 6'd28);
        chk("frame_starts",     6'(c_fs), 6'd1);
        chk("fetches",          6'(c_fe), 6'd32);
        chk("uf_clean_frame",   6'(o_underflow), 6'd0);

        drop_pos = 1 * H_TOT + 3;
        goto_px(3, 1);
        chk("drop_rgb", o_rgb, 6'd0);
        chk("drop_uf",  6'(o_underflow), 6'd1);
        drop_pos = -1;
        goto_px(5, 2);
        chk("fb_px_5_2", o_rgb, 6'd5);
        goto_px(13, 7);
        chk("uf_sticky", 6'(o_underflow), 6'd1);
        goto_px(0, 0);
        chk("uf_cleared", 6'(o_underflow), 6'd0);
        chk("fs_pulse",   6'(o_frame_start), 6'd1);

        goto_px(0, 2);
        i_mode = 2'd2;
        goto_px(5, 3);
        chk("switch_same_frame", o_rgb, 6'd5);
        goto_px(5, 0);
        chk("switch_next_frame", o_rgb, 6'd0);

        i_mode = 2'd1;
        goto_px(13, 7);
        goto_px(5, 0);
        chk("bar5", o_rgb, 6'b110011);
        i_mode = 2'd3;
        goto_px(13, 7);
        goto_px(2, 1);
        chk("white_active", o_rgb, 6'h3f);
        goto_px(9, 1);
        chk("white_blank", o_rgb, 6'h00);

        goto_px(4, 2);
        #2;
        reset_ = 1'b0;
        #1;
        model_reset();
        chk("async_fetch", 6'(o_fetch_next_pixel), 6'd0);
        chk("async_rgb",   o_rgb, 6'd0);
        chk("async_hs",    6'(o_h_sync), 6'd1);
        chk("async_uf",    6'(o_underflow), 6'd0);
        repeat (2) tick();
        reset_ = 1'b1;
        i_mode = 2'd0;
        repeat (F_TOT + 20) tick();
        i_enable = 1'b0;
        repeat (3) tick();
        chk("idle_fetch", 6'(o_fetch_next_pixel), 6'd0);
        chk("idle_vs",    6'(o_v_sync), 6'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
